// File: rtl/move_pkg.sv
// move_pkg: move codes, PS/2 scan-code table, undo key and scheduler state encoding
package move_pkg;

    localparam int         NUM_MOVES = 12;
    localparam logic [3:0] MV_CCW    = 4'd1;
    localparam logic [7:0] UNDO_KEY  = 8'h66;

    // Indexed by move code face*2+dir: U,Y,D,S,L,K,R,E,F,G,B,N
    localparam logic [7:0] SCAN_TBL [NUM_MOVES] = '{
        8'h3C, 8'h35, 8'h23, 8'h1B, 8'h4B, 8'h42,
        8'h2D, 8'h24, 8'h2B, 8'h34, 8'h32, 8'h31
    };

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SCR} state_e;

    // Returns {hit, move_code}
    function automatic logic [4:0] key_lookup(input logic [7:0] k);
        key_lookup = 5'd0;
        for (int i = 0; i < NUM_MOVES; i++)
            if (SCAN_TBL[i] == k) key_lookup = {1'b1, 4'(i)};
    endfunction

    function automatic logic [3:0] mod12(input logic [3:0] r);
        return (r >= 4'd12) ? r - 4'd12 : r;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: synchronous FIFO of move entries with flush; DEPTH is a power of two >= 2
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];
    assign count   = cnt_q;

    // storage and pointers; flush empties without touching the storage
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/move_sched.sv
// move_sched: keyboard/scramble move scheduler; MOVE_UNDO_EN adds an undo history stack
module move_sched
    import move_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SCR_LEN    = 20
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic       scr_start,
    input  logic [3:0] rnd,
    output logic       mv_valid,
    output logic [3:0] mv_code,
    input  logic       mv_ready,
    output logic       busy,
    output logic       scr_active,
    output logic       ovf,
    output logic [7:0] mv_count
);
`ifdef MOVE_UNDO_EN
    localparam int FW = 5;
`else
    localparam int FW = 4;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic          mv_valid_q, mv_valid_d;
    logic [3:0]    mv_code_q, mv_code_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    scr_q, scr_d;
    logic [FW-1:0] f_din, f_dout;
    logic          f_empty, f_full;
    logic [CW-1:0] f_count;
    logic [4:0]    hit;
    logic          xfer, scr_go, undo_req, key_req, key_ok, key_drop;

    assign hit      = key_lookup(key_code);
    assign xfer     = mv_valid_q && mv_ready;
    assign scr_go   = scr_start && (state_q == ST_IDLE || (state_q == ST_ISSUE && xfer));
    assign key_req  = (key_valid && hit[4]) || undo_req;
    assign key_ok   = key_req && !scr_go && state_q != ST_SCR && !f_full;
    assign key_drop = key_req && !scr_go && (state_q == ST_SCR || f_full);

`ifdef MOVE_UNDO_EN
    logic [3:0] stk_q [8];
    logic [3:0] stk_cnt_q;
    logic       uflag_q, rec, undo_ok;

    assign undo_req = key_valid && key_code == UNDO_KEY && stk_cnt_q != 4'd0;
    assign undo_ok  = undo_req && key_ok;
    assign f_din    = undo_req ? {1'b1, stk_q[0] ^ MV_CCW} : {1'b0, hit[3:0]};
    assign rec      = state_q == ST_ISSUE && xfer && !uflag_q && !scr_go;

    // history stack, top at index 0; pushing onto a full stack shifts the oldest out
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 8; i++) stk_q[i] <= '0;
            stk_cnt_q <= '0;
            uflag_q   <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE && !mv_valid_q) uflag_q <= f_dout[4];
            if (scr_go) stk_cnt_q <= '0;
            else if (rec && undo_ok) stk_q[0] <= mv_code_q;
            else if (rec) begin
                for (int i = 7; i > 0; i--) stk_q[i] <= stk_q[i-1];
                stk_q[0]  <= mv_code_q;
                stk_cnt_q <= (stk_cnt_q == 4'd8) ? stk_cnt_q : stk_cnt_q + 4'd1;
            end else if (undo_ok) begin
                for (int i = 0; i < 7; i++) stk_q[i] <= stk_q[i+1];
                stk_cnt_q <= stk_cnt_q - 4'd1;
            end
        end
    end
`else
    assign undo_req = 1'b0;
    assign f_din    = hit[3:0];
`endif

    // the offered entry stays in the FIFO until it transfers, so full counts it
    move_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (scr_go),
        .push  (key_ok),
        .din   (f_din),
        .pop   (state_q == ST_ISSUE && xfer),
        .dout  (f_dout),
        .empty (f_empty),
        .full  (f_full),
        .count (f_count)
    );

    // next state: a move is loaded one cycle after it is needed, giving the bubble
    always_comb begin
        state_d    = state_q;
        mv_valid_d = mv_valid_q;
        mv_code_d  = mv_code_q;
        ovf_d      = ovf_q | key_drop;
        cnt_d      = cnt_q + {7'd0, xfer};
        scr_d      = scr_q;
        if (scr_go) begin
            state_d    = ST_SCR;
            mv_valid_d = 1'b0;
            ovf_d      = 1'b0;
            scr_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = f_empty ? ST_IDLE : ST_ISSUE;
                ST_ISSUE: begin
                    if (!mv_valid_q) begin
                        mv_valid_d = 1'b1;
                        mv_code_d  = f_dout[3:0];
                    end else if (xfer) begin
                        mv_valid_d = 1'b0;
                        state_d    = (f_count == CW'(1)) ? ST_IDLE : ST_ISSUE;
                    end
                end
                ST_SCR: begin
                    if (!mv_valid_q) begin
                        mv_valid_d = 1'b1;
                        mv_code_d  = mod12(rnd);
                    end else if (xfer) begin
                        mv_valid_d = 1'b0;
                        scr_d      = scr_q + 8'd1;
                        state_d    = (scr_q == 8'(SCR_LEN - 1)) ? ST_IDLE : ST_SCR;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            mv_valid_q <= 1'b0;
            mv_code_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            scr_q      <= '0;
        end else begin
            state_q    <= state_d;
            mv_valid_q <= mv_valid_d;
            mv_code_q  <= mv_code_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            scr_q      <= scr_d;
        end
    end

    assign mv_valid   = mv_valid_q;
    assign mv_code    = mv_code_q;
    assign ovf        = ovf_q;
    assign mv_count   = cnt_q;
    assign busy       = state_q != ST_IDLE || !f_empty;
    assign scr_active = state_q == ST_SCR;

endmodule

// File: tb/tb_move_sched.sv
// tb_move_sched: directed and random checks of move_sched against a queue-based model
module tb_move_sched;
    localparam int FIFO_DEPTH = 4;
    localparam int SCR_LEN    = 20;

    logic       clk = 0, clr_n = 0;
    logic [7:0] key_code = 0;
    logic       key_valid = 0, scr_start = 0, mv_ready = 0;
    logic [3:0] rnd = 0;
    logic       mv_valid, busy, scr_active, ovf;
    logic [3:0] mv_code;
    logic [7:0] mv_count;
    int total = 0, bad = 0;

    logic [7:0] tbl [12] = '{8'h3C, 8'h35, 8'h23, 8'h1B, 8'h4B, 8'h42,
                             8'h2D, 8'h24, 8'h2B, 8'h34, 8'h32, 8'h31};
    logic [7:0] k5 [5] = '{8'h3C, 8'h23, 8'h4B, 8'h2D, 8'h2B};
    int         e5 [4] = '{0, 2, 4, 6};

    always #5 clk = ~clk;

    move_sched #(.FIFO_DEPTH(FIFO_DEPTH), .SCR_LEN(SCR_LEN)) dut (
        .clk(clk), .clr_n(clr_n), .key_code(key_code), .key_valid(key_valid),
        .scr_start(scr_start), .rnd(rnd), .mv_valid(mv_valid), .mv_code(mv_code),
        .mv_ready(mv_ready), .busy(busy), .scr_active(scr_active), .ovf(ovf),
        .mv_count(mv_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int kmap(input logic [7:0] k);
        case (k)
            8'h3C: return 0;  8'h35: return 1;
            8'h23: return 2;  8'h1B: return 3;
            8'h4B: return 4;  8'h42: return 5;
            8'h2D: return 6;  8'h24: return 7;
            8'h2B: return 8;  8'h34: return 9;
            8'h32: return 10; 8'h31: return 11;
            default: return -1;
        endcase
    endfunction

    // model: mq holds pending user moves (head may be on offer), +16 marks an undo move
    int mq[$];
    int m_stk[$];
    bit m_valid, m_ovf;
    int m_code, m_mode, m_cnt, m_done;

    always @(posedge clk or negedge clr_n) begin
        bit xf, go, req, acc, undo;
        int k, ent;
        if (!clr_n) begin
            mq.delete(); m_stk.delete();
            m_valid = 0; m_code = 0; m_mode = 0; m_cnt = 0; m_ovf = 0; m_done = 0;
        end else begin
            xf   = m_valid && mv_ready;
            go   = scr_start && (m_mode == 0 || (m_mode == 1 && xf));
            k    = key_valid ? kmap(key_code) : -1;
            ent  = k;
            undo = 0;
`ifdef MOVE_UNDO_EN
            if (key_valid && key_code == 8'h66 && m_stk.size() > 0) begin
                undo = 1;
                ent  = 16 + (m_stk[0] ^ 1);
            end
`endif
            req = (k >= 0) || undo;
            acc = req && !go && m_mode != 2 && mq.size() < FIFO_DEPTH;
            if (req && !go && !acc) m_ovf = 1;
            if (xf) m_cnt = (m_cnt + 1) % 256;
            if (undo && acc) void'(m_stk.pop_front());
            if (go) begin
                mq.delete(); m_stk.delete();
                m_ovf = 0; m_mode = 2; m_valid = 0; m_done = 0;
            end else if (m_mode == 0) begin
                if (mq.size() > 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!m_valid) begin
                    m_valid = 1;
                    m_code  = mq[0] % 16;
                end else if (xf) begin
                    if (mq[0] < 16) begin
                        m_stk.push_front(m_code);
                        if (m_stk.size() > 8) void'(m_stk.pop_back());
                    end
                    void'(mq.pop_front());
                    m_valid = 0;
                    if (mq.size() == 0) m_mode = 0;
                end
            end else begin
                if (!m_valid) begin
                    m_valid = 1;
                    m_code  = rnd % 12;
                end else if (xf) begin
                    m_valid = 0;
                    m_done++;
                    if (m_done == SCR_LEN) m_mode = 0;
                end
            end
            if (acc) mq.push_back(ent);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("mv_valid", mv_valid, m_valid);
        if (m_valid) chk("mv_code", mv_code, m_code);
        chk("busy", busy, (m_mode != 0 || mq.size() > 0));
        chk("scr_active", scr_active, m_mode == 2);
        chk("ovf", ovf, m_ovf);
        chk("mv_count", mv_count, m_cnt);
    end

    int xq[$];
    always @(posedge clk) if (clr_n && mv_valid && mv_ready) xq.push_back(int'(mv_code));

    task automatic key(input logic [7:0] c);
        @(negedge clk); key_valid = 1; key_code = c;
        @(negedge clk); key_valid = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || scr_active) && n < budget) begin @(negedge clk); n++; end
        chk(name, busy, 0);
    endtask

    task automatic wait_scr(input string name, input int budget);
        int n = 0;
        while (scr_active && n < budget) begin @(negedge clk); n++; end
        chk(name, scr_active, 0);
    endtask

    function automatic int count_code(input int c);
        int n = 0;
        foreach (xq[i]) if (xq[i] == c) n++;
        return n;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, mv_valid, 0);
        chk({tag, "_code"}, mv_code, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_scr"}, scr_active, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_count"}, mv_count, 0);
    endtask

    initial begin
        int n, sel;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        clr_n = 1;

        // single key, latency and count
        mv_ready = 1;
        @(negedge clk); key_valid = 1; key_code = 8'h2D;
        @(negedge clk); key_valid = 0;
        @(negedge clk); chk("lat_early", mv_valid, 0);
        @(negedge clk); chk("lat_valid", mv_valid, 1); chk("lat_code", mv_code, 6);
        @(negedge clk); chk("one_count", mv_count, 1); chk("one_busy", busy, 0);

        // five keys into a depth-4 queue while stalled
        mv_ready = 0; xq.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); key_valid = 1; key_code = k5[i];
        end
        @(negedge clk); key_valid = 0;
        repeat (5) @(negedge clk);
        chk("stall_none", xq.size(), 0);
        chk("ovf_set", ovf, 1);
        mv_ready = 1;
        wait_idle("drain_idle", 100);
        chk("drain_n", xq.size(), 4);
        for (int i = 0; i < 4; i++) chk("drain_order", (i < xq.size()) ? xq[i] : -1, e5[i]);

        // scramble with rnd=13
        xq.delete();
        @(negedge clk); scr_start = 1; rnd = 13;
        @(negedge clk); scr_start = 0;
        chk("scr_on", scr_active, 1); chk("scr_ovf_clr", ovf, 0);
        wait_scr("scr_end", 200);
        chk("scr_n", xq.size(), 20);
        chk("scr_code", count_code(1), 20);
        chk("scr_count", mv_count, 25);

        // scramble and key in the same cycle
        xq.delete();
        @(negedge clk); scr_start = 1; key_valid = 1; key_code = 8'h3C; rnd = 5;
        @(negedge clk); scr_start = 0; key_valid = 0;
        wait_scr("mix_end", 200);
        chk("mix_n", xq.size(), 20);
        chk("mix_code", count_code(5), 20);
        chk("mix_ovf", ovf, 0);
        chk("mix_count", mv_count, 45);

        // backspace
        xq.delete();
`ifdef MOVE_UNDO_EN
        key(8'h4B); wait_idle("undo_a", 50);
        key(8'h66); wait_idle("undo_b", 50);
        key(8'h66); repeat (10) @(negedge clk);
        chk("undo_n", xq.size(), 2);
        chk("undo_first", (xq.size() > 0) ? xq[0] : -1, 4);
        chk("undo_second", (xq.size() > 1) ? xq[1] : -1, 5);
`else
        key(8'h66); repeat (10) @(negedge clk);
        chk("bksp_n", xq.size(), 0);
        chk("bksp_busy", busy, 0);
`endif

        // reset during scramble move 7
        xq.delete();
        @(negedge clk); scr_start = 1; rnd = 7;
        @(negedge clk); scr_start = 0;
        n = 0;
        while (xq.size() < 6 && n < 200) begin @(negedge clk); n++; end
        chk("mid_reach", xq.size(), 6);
        clr_n = 0;
        #1 chk_reset_outputs("mid_rst");
        @(negedge clk); clr_n = 1; xq.delete();
        repeat (20) @(negedge clk);
        chk("post_rst_n", xq.size(), 0);
        chk("post_rst_busy", busy, 0);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            key_valid = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 13);
            key_code = (sel < 12) ? tbl[sel] : (sel == 12) ? 8'h66 : 8'($urandom);
            scr_start = ($urandom_range(0, 60) == 0);
            rnd = 4'($urandom);
            mv_ready = (c < 750) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            clr_n = ($urandom_range(0, 400) != 0);
        end
        @(negedge clk);
        key_valid = 0; scr_start = 0; clr_n = 1; mv_ready = 1;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
